// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the backing-memory port arbiter: FSM states,
// transaction op and arbitration mode selectors.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   localparam int RR_FIXED = 0;
   localparam int RR_ROUND = 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the client request ports and the memory readM/writeM/ack port.
// slave = arbiter view, master = clients plus memory model view.
interface mem_port_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 16,
   parameter int LINE_W = 64
);

   logic [NUM_CH-1:0]        ch_read;
   logic [NUM_CH-1:0]        ch_write;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*LINE_W-1:0] ch_wdata;
   logic [NUM_CH-1:0]        ch_grant;
   logic [NUM_CH-1:0]        ch_done;
   logic [LINE_W-1:0]        ch_rdata;
   logic                     mem_readM;
   logic                     mem_writeM;
   logic [ADDR_W-1:0]        mem_address;
   logic [LINE_W-1:0]        mem_wdata;
   logic [LINE_W-1:0]        mem_rdata;
   logic                     mem_read_ack;
   logic                     mem_write_ack;
   logic                     timeout_err;

   modport slave (
      input  ch_read, ch_write, ch_addr, ch_wdata,
      input  mem_rdata, mem_read_ack, mem_write_ack,
      output ch_grant, ch_done, ch_rdata,
      output mem_readM, mem_writeM, mem_address, mem_wdata, timeout_err
   );

   modport master (
      output ch_read, ch_write, ch_addr, ch_wdata,
      output mem_rdata, mem_read_ack, mem_write_ack,
      input  ch_grant, ch_done, ch_rdata,
      input  mem_readM, mem_writeM, mem_address, mem_wdata, timeout_err
   );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// Combinational winner pick: first pending channel at or after the base
// index (pointer in round-robin mode, zero in fixed mode), wrapping.
module mem_port_arbiter_select
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int RR_MODE = RR_FIXED,
   parameter int PTR_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] pend_i,
   input  logic [PTR_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic              valid_o
);

   logic [PTR_W-1:0] base_s;
   logic [PTR_W:0]   idx_s;
   logic             found_s;

   // scan channels starting from base, first pending one wins
   always_comb begin
      base_s  = (RR_MODE == RR_ROUND) ? ptr_i : {PTR_W{1'b0}};
      grant_o = {NUM_CH{1'b0}};
      found_s = 1'b0;
      idx_s   = {(PTR_W+1){1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         idx_s = {1'b0, base_s} + (PTR_W+1)'(k);
         idx_s = (idx_s >= (PTR_W+1)'(NUM_CH)) ? (idx_s - (PTR_W+1)'(NUM_CH)) : idx_s;
         if (!found_s && pend_i[idx_s[PTR_W-1:0]]) begin
            grant_o[idx_s[PTR_W-1:0]] = 1'b1;
            found_s                   = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      valid_o = found_s;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide backing-memory port among NUM_CH cache clients with
// registered grants, per-channel done pulses and a sticky stall watchdog.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 16,
   parameter int LINE_W  = 64,
   parameter int RR_MODE = RR_FIXED,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam int                PTR_W     = $clog2(NUM_CH);
   localparam logic [ADDR_W-1:0] TIMEOUT_C = ADDR_W'(TIMEOUT);

   state_e              state_q;
   op_e                 op_q;
   logic [NUM_CH-1:0]   grant_q;
   logic [NUM_CH-1:0]   done_q;
   logic [PTR_W-1:0]    owner_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wdata_q;
   logic [LINE_W-1:0]   rdata_q;
   logic                readm_q;
   logic                writem_q;
   logic [ADDR_W-1:0]   wd_cnt_q;
   logic                err_q;

   logic [NUM_CH-1:0]   pend_s;
   logic [NUM_CH-1:0]   win_oh_s;
   logic                win_valid_s;
   logic [ADDR_W-1:0]   sel_addr_d;
   logic [LINE_W-1:0]   sel_wdata_d;
   logic                sel_wr_d;
   logic [PTR_W-1:0]    sel_idx_d;
   logic                ack_match_d;
   logic [ADDR_W-1:0]   wd_cnt_d;
   logic [PTR_W-1:0]    ptr_d;

   assign pend_s = bus.ch_read | bus.ch_write;

   mem_port_arbiter_select #(
      .NUM_CH  (NUM_CH),
      .RR_MODE (RR_MODE),
      .PTR_W   (PTR_W)
   ) u_select (
      .pend_i  (pend_s),
      .ptr_i   (ptr_q),
      .grant_o (win_oh_s),
      .valid_o (win_valid_s)
   );

   // route the winning channel's address, data and op toward the latches;
   // write wins over read so a dirty line goes out before its refill
   always_comb begin
      sel_addr_d  = {ADDR_W{1'b0}};
      sel_wdata_d = {LINE_W{1'b0}};
      sel_wr_d    = 1'b0;
      sel_idx_d   = {PTR_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_oh_s[i]) begin
            sel_addr_d  = bus.ch_addr[i*ADDR_W +: ADDR_W];
            sel_wdata_d = bus.ch_wdata[i*LINE_W +: LINE_W];
            sel_wr_d    = bus.ch_write[i];
            sel_idx_d   = PTR_W'(i);
         end else begin
            sel_wr_d = sel_wr_d;
         end
      end
   end

   // ack qualification, saturating watchdog increment and next RR pointer
   always_comb begin
      ack_match_d = (op_q == OP_READ) ? bus.mem_read_ack : bus.mem_write_ack;
      wd_cnt_d    = (wd_cnt_q == {ADDR_W{1'b1}}) ? wd_cnt_q : (wd_cnt_q + ADDR_W'(1));
      ptr_d       = (owner_q == PTR_W'(NUM_CH-1)) ? {PTR_W{1'b0}} : (owner_q + PTR_W'(1));
   end

   // transaction FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_READ;
         grant_q  <= {NUM_CH{1'b0}};
         done_q   <= {NUM_CH{1'b0}};
         owner_q  <= {PTR_W{1'b0}};
         ptr_q    <= {PTR_W{1'b0}};
         addr_q   <= {ADDR_W{1'b0}};
         wdata_q  <= {LINE_W{1'b0}};
         rdata_q  <= {LINE_W{1'b0}};
         readm_q  <= 1'b0;
         writem_q <= 1'b0;
         wd_cnt_q <= {ADDR_W{1'b0}};
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= {NUM_CH{1'b0}};
               if (win_valid_s) begin
                  state_q  <= ST_BUSY;
                  grant_q  <= win_oh_s;
                  owner_q  <= sel_idx_d;
                  op_q     <= sel_wr_d ? OP_WRITE : OP_READ;
                  addr_q   <= sel_addr_d;
                  wdata_q  <= sel_wdata_d;
                  readm_q  <= ~sel_wr_d;
                  writem_q <= sel_wr_d;
                  wd_cnt_q <= {ADDR_W{1'b0}};
               end else begin
                  state_q  <= ST_IDLE;
                  grant_q  <= {NUM_CH{1'b0}};
                  readm_q  <= 1'b0;
                  writem_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (ack_match_d) begin
                  state_q  <= ST_DONE;
                  done_q   <= grant_q;
                  grant_q  <= {NUM_CH{1'b0}};
                  readm_q  <= 1'b0;
                  writem_q <= 1'b0;
                  if (op_q == OP_READ) begin
                     rdata_q <= bus.mem_rdata;
                  end else begin
                     rdata_q <= rdata_q;
                  end
               end else begin
                  state_q  <= ST_BUSY;
                  wd_cnt_q <= wd_cnt_d;
                  if ((TIMEOUT != 0) && (wd_cnt_d == TIMEOUT_C)) begin
                     err_q <= 1'b1;
                  end else begin
                     err_q <= err_q;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= {NUM_CH{1'b0}};
               if (RR_MODE == RR_ROUND) begin
                  ptr_q <= ptr_d;
               end else begin
                  ptr_q <= {PTR_W{1'b0}};
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               grant_q  <= {NUM_CH{1'b0}};
               done_q   <= {NUM_CH{1'b0}};
               readm_q  <= 1'b0;
               writem_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ch_grant    = grant_q;
   assign bus.ch_done     = done_q;
   assign bus.ch_rdata    = rdata_q;
   assign bus.mem_readM   = readm_q;
   assign bus.mem_writeM  = writem_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.timeout_err = err_q;

endmodule
